video_timing_gen: RTL and testbench

- Parametrised raster timing generator for the arcade video path; successor to the fixed 256x240 generator.
- Produces H/V counters, blanking, sync, data-enable and line/frame strobes from a pixel clock-enable on the system clock.
- Gates incoming RGB to black outside the active area.
- Adds a runtime left-column mask, latched once per frame and used for the column-bug fix, plus a field toggle.
- Sits between the board RGB output and the arcade_video/scandoubler chain.

---
 rtl/video_timing_gen.sv | 138 +++++++++++++
 tb/tb_video_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, blank/sync/DE, line/frame strobes
// and RGB gating with a per-frame left-column mask and a field toggle.
//
// Ports:
//   clk_sys     system clock, all state on its rising edge
//   reset_n     asynchronous active-low reset
//   ce_pix      pixel clock enable; nothing advances while it is low
//   left_mask   leading active columns forced blank, latched at frame start
//   rgb_in      board pixel for the current counter position
//   hcnt/vcnt   raster position counters
//   hb/vb       horizontal/vertical blank, active high
//   hs/vs       horizontal/vertical sync, active low
//   de          data enable (~hb & ~vb)
//   rgb_out     rgb_in, forced to 0 while blanked
//   line_start  one-ce pulse on the first pixel of every line
//   frame_start one-ce pulse on the first pixel of line 0
//   field       toggles on every frame_start
module video_timing_gen #(
    parameter int H_ACTIVE = 256,
    parameter int H_TOTAL  = 318,
    parameter int HS_START = 283,
    parameter int HS_END   = 303,
    parameter int V_ACTIVE = 240,
    parameter int V_TOTAL  = 256,
    parameter int VS_START = 251,
    parameter int VS_END   = 254,
    parameter int HCNT_W   = 9,
    parameter int VCNT_W   = 8,
    parameter int RGB_W    = 24
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [HCNT_W-1:0] left_mask,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic              hb,
    output logic              vb,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              line_start,
    output logic              frame_start,
    output logic              field
);

    localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ACT  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] HS_B   = HCNT_W'(HS_START);
    localparam logic [HCNT_W-1:0] HS_E   = HCNT_W'(HS_END);
    localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ACT  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] VS_B   = VCNT_W'(VS_START);
    localparam logic [VCNT_W-1:0] VS_E   = VCNT_W'(VS_END);

    logic              h_wrap;
    logic              v_wrap;
    logic              at_origin;
    logic [HCNT_W-1:0] hcnt_nx;
    logic [VCNT_W-1:0] vcnt_nx;
    logic [HCNT_W-1:0] mask_q;
    logic [HCNT_W-1:0] mask_eff;
    logic              hb_nx;
    logic              vb_nx;
    logic              hs_nx;
    logic              vs_nx;
    logic              de_nx;
    logic [RGB_W-1:0]  rgb_nx;

    // Counter advance and decode of the current (pre-increment) position.
    always_comb begin
        h_wrap    = (hcnt == H_LAST);
        v_wrap    = (vcnt == V_LAST);
        at_origin = (hcnt == '0) && (vcnt == '0);

        hcnt_nx = h_wrap ? '0 : hcnt + 1'b1;
        vcnt_nx = vcnt;
        if (h_wrap) begin
            vcnt_nx = v_wrap ? '0 : vcnt + 1'b1;
        end

        // The new mask applies to column 0 of line 0 itself, so bypass
        // the register in the cycle it is captured.
        mask_eff = at_origin ? left_mask : mask_q;

        hb_nx  = (hcnt < mask_eff) || (hcnt >= H_ACT);
        vb_nx  = (vcnt >= V_ACT);
        hs_nx  = !((hcnt >= HS_B) && (hcnt < HS_E));
        vs_nx  = !((vcnt >= VS_B) && (vcnt < VS_E));
        de_nx  = !hb_nx && !vb_nx;
        rgb_nx = de_nx ? rgb_in : '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce_pix) begin
            hcnt <= hcnt_nx;
            vcnt <= vcnt_nx;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            field  <= 1'b0;
        end else if (ce_pix && at_origin) begin
            mask_q <= left_mask;
            field  <= !field;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hb          <= 1'b1;
            vb          <= 1'b1;
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
            rgb_out     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce_pix) begin
            hb          <= hb_nx;
            vb          <= vb_nx;
            hs          <= hs_nx;
            vs          <= vs_nx;
            de          <= de_nx;
            rgb_out     <= rgb_nx;
            line_start  <= (hcnt == '0);
            frame_start <= at_origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen on a reduced raster, checked
// every clock against a position-from-ce-count reference model.
module tb_video_timing_gen;

    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSE = 21;
    localparam int VA  = 10;
    localparam int VT  = 14;
    localparam int VSS = 11;
    localparam int VSE = 13;
    localparam int HW  = 5;
    localparam int VW  = 4;
    localparam int CW  = 24;
    localparam int FRAME = HT * VT;

    logic          clk_sys;
    logic          reset_n;
    logic          ce_pix;
    logic [HW-1:0] left_mask;
    logic [CW-1:0] rgb_in;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hb, vb, hs, vs, de;
    logic [CW-1:0] rgb_out;
    logic          line_start, frame_start, field;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_TOTAL(HT),
        .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT),
        .VS_START(VSS), .VS_END(VSE),
        .HCNT_W(HW), .VCNT_W(VW), .RGB_W(CW)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ce_pix(ce_pix),
        .left_mask(left_mask),
        .rgb_in(rgb_in),
        .hcnt(hcnt),
        .vcnt(vcnt),
        .hb(hb),
        .vb(vb),
        .hs(hs),
        .vs(vs),
        .de(de),
        .rgb_out(rgb_out),
        .line_start(line_start),
        .frame_start(frame_start),
        .field(field)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raster position is just the ce count since reset.
    int          n;
    int          mask_m;
    logic        field_m;
    logic        e_hb, e_vb, e_hs, e_vs, e_de, e_ls, e_fs;
    logic [CW-1:0] e_rgb;

    int  ce_phase = 0;
    bit  rgb_ones = 0;
    bit  mask_rand = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int cur_h();
        return (n % FRAME) % HT;
    endfunction

    function automatic int cur_v();
        return (n % FRAME) / HT;
    endfunction

    task automatic model_reset();
        n = 0;
        mask_m = 0;
        field_m = 1'b0;
        e_hb = 1'b1; e_vb = 1'b1;
        e_hs = 1'b1; e_vs = 1'b1;
        e_de = 1'b0; e_rgb = '0;
        e_ls = 1'b0; e_fs = 1'b0;
    endtask

    task automatic model_step();
        int h, v;
        h = cur_h();
        v = cur_v();
        if (h == 0 && v == 0) begin
            mask_m = int'(left_mask);
            field_m = !field_m;
        end
        e_hb  = (h < mask_m) || (h >= HA);
        e_vb  = (v >= VA);
        e_hs  = !(h >= HSS && h < HSE);
        e_vs  = !(v >= VSS && v < VSE);
        e_de  = !e_hb && !e_vb;
        e_rgb = e_de ? rgb_in : '0;
        e_ls  = (h == 0);
        e_fs  = (h == 0 && v == 0);
        n++;
    endtask

    task automatic check_all();
        chk("hcnt", 32'(hcnt), 32'(cur_h()));
        chk("vcnt", 32'(vcnt), 32'(cur_v()));
        chk("hb", 32'(hb), 32'(e_hb));
        chk("vb", 32'(vb), 32'(e_vb));
        chk("hs", 32'(hs), 32'(e_hs));
        chk("vs", 32'(vs), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("rgb_out", 32'(rgb_out), 32'(e_rgb));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("field", 32'(field), 32'(field_m));
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (!reset_n) model_reset();
        else if (ce_pix) model_step();
        check_all();
    endtask

    // mode 0: ce every 2nd clk, 1: random, 2: always, 3: never
    task automatic drive(input int mode);
        ce_phase++;
        case (mode)
            0: ce_pix = ce_phase[0];
            1: ce_pix = ($urandom_range(0, 3) != 0);
            2: ce_pix = 1'b1;
            default: ce_pix = 1'b0;
        endcase
        rgb_in = rgb_ones ? {CW{1'b1}} : CW'($urandom);
        if (mask_rand && $urandom_range(0, 7) == 0)
            left_mask = HW'($urandom_range(0, 31));
    endtask

    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            drive(mode);
            tick();
        end
    endtask

    task automatic run_to(input int h, input int v, input int mode);
        bit hit;
        hit = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (cur_h() == h && cur_v() == v) begin
                hit = 1;
                break;
            end
            drive(mode);
            tick();
        end
        chk("run_to_reached", 32'(hit), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        ce_pix    = 1'b0;
        left_mask = '0;
        rgb_in    = '0;
        model_reset();
        run(4, 3);
        reset_n = 1'b1;

        // Nominal raster, ce every other clock, no mask.
        run(2 * (2 * FRAME + 40), 0);

        // Mask of 5 with white input, then drop it to 0 mid-frame.
        rgb_ones = 1;
        left_mask = HW'(5);
        run_to(0, 0, 1);
        run_to(3, 5, 1);
        left_mask = '0;
        run_to(0, 0, 1);
        run(FRAME + 20, 1);
        rgb_ones = 0;

        // Mask covering the whole active width.
        left_mask = HW'(HA + 2);
        run(2 * FRAME, 2);

        // Randomly changing mask and irregular ce.
        mask_rand = 1;
        run(4 * FRAME, 1);
        mask_rand = 0;

        // Freeze mid-line for 50 clocks.
        left_mask = HW'(3);
        run_to(9, 4, 1);
        run(50, 3);
        run(3 * HT, 1);

        // Asynchronous reset mid-frame.
        run_to(10, 6, 2);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        run(3, 1);
        reset_n = 1'b1;
        run(FRAME + FRAME / 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
